video_window_timing: RTL and testbench



---
 rtl/video_pkg.sv | 28 ++
 rtl/sig_delay.sv | 27 ++
 rtl/video_window_timing.sv | 159 +++++++++++++++
 tb/tb_video_window_timing.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types and helpers for the video window timing block.
package video_pkg;

   localparam int COLOR_W_DEF = 12;

   typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} region_e;

   typedef struct packed {
      logic hs;
      logic vs;
      logic hblank;
      logic vblank;
      logic win;
   } vflags_t;

   function automatic int timing_total(int act, int fp, int sync, int bp);
      return act + fp + sync + bp;
   endfunction

   // Regions are ordered active, front porch, sync, back porch.
   function automatic region_e region_of(int pos, int act, int fp, int sync);
      if (pos < act)             return ACTIVE;
      if (pos < act + fp)        return FP;
      if (pos < act + fp + sync) return SYNC;
      return BP;
   endfunction

endpackage

// File: rtl/sig_delay.sv
// Width/depth shift register advanced by ce, reset to a fixed value.
module sig_delay #(
   parameter int             W       = 1,
   parameter int             DEPTH   = 1,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         ce,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [DEPTH-1:0][W-1:0] stg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stg <= {DEPTH{RST_VAL}};
      end else if (ce) begin
         for (int i = DEPTH - 1; i > 0; i--) stg[i] <= stg[i-1];
         stg[0] <= d;
      end
   end

   assign q = stg[DEPTH-1];

endmodule

// File: rtl/video_window_timing.sv
// Programmable video timing with an image window and multiplier-free fb addressing.
// Define VWT_PIXEL_DOUBLE_EN to show each framebuffer pixel as a 2x2 screen block.
module video_window_timing
   import video_pkg::*;
#(
   parameter int ADDR_W   = 20,
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1,
   parameter int IMG_X0   = 0,
   parameter int IMG_Y0   = 110,
   parameter int IMG_W    = 1280,
   parameter int IMG_H    = 500,
   parameter int COLOR_W  = COLOR_W_DEF,
   parameter int PIPE_LAT = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               ce_pix,
   input  logic [COLOR_W-1:0] border_color,
   input  logic [COLOR_W-1:0] pixel_in,
   output logic [10:0]        x,
   output logic [9:0]         y,
   output logic [ADDR_W-1:0]  fb_addr,
   output logic               fb_rd,
   output logic               frame_start,
   output logic [COLOR_W-1:0] rgb,
   output logic               hs,
   output logic               vs,
   output logic               hblank,
   output logic               vblank
);

`ifdef VWT_PIXEL_DOUBLE_EN
   localparam int SCALE = 2;
`else
   localparam int SCALE = 1;
`endif

   localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int WIN_W   = IMG_W * SCALE;
   localparam int WIN_H   = IMG_H * SCALE;
   localparam int HW      = (H_TOTAL > 2) ? $clog2(H_TOTAL) : 1;
   localparam int VW      = (V_TOTAL > 2) ? $clog2(V_TOTAL) : 1;

   localparam logic [HW-1:0]     H_LAST    = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0]     V_LAST    = VW'(V_TOTAL - 1);
   localparam logic [HW-1:0]     X_LO      = HW'(IMG_X0);
   localparam logic [VW-1:0]     Y_LO      = VW'(IMG_Y0);
   localparam logic [HW-1:0]     WIN_W_C   = HW'(WIN_W);
   localparam logic [HW-1:0]     WIN_XLAST = HW'(WIN_W - 1);
   localparam logic [VW-1:0]     WIN_H_C   = VW'(WIN_H);
   localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(IMG_W);

   localparam vflags_t FLAGS_RST = '{hs: ~HS_POL, vs: ~VS_POL, hblank: 1'b1,
                                     vblank: 1'b1, win: 1'b0};

   if (IMG_X0 < 0 || IMG_Y0 < 0 || IMG_W < 1 || IMG_H < 1 ||
       IMG_X0 + WIN_W > H_ACTIVE || IMG_Y0 + WIN_H > V_ACTIVE) begin : g_bad_window
      $error("video_window_timing: image window must lie inside the active area");
   end
   if (PIPE_LAT < 1) begin : g_bad_lat
      $error("video_window_timing: PIPE_LAT must be at least 1");
   end

   logic [HW-1:0]     h, h_nxt, hoff, hoff_n;
   logic [VW-1:0]     v, v_nxt, voff, voff_n;
   logic              h_wrap, v_wrap, win, win_n;
   logic              adv_line, step_pix;
   logic [ADDR_W-1:0] line_base, lb_nxt;
   vflags_t           flags_now, flags_dly;

   always_comb begin
      h_wrap = (h == H_LAST);
      v_wrap = h_wrap && (v == V_LAST);
      h_nxt  = h_wrap ? '0 : h + 1'b1;
      v_nxt  = v_wrap ? '0 : (h_wrap ? v + 1'b1 : v);
   end

   // Offsets wrap below the window origin, so one unsigned compare covers both bounds.
   assign hoff   = h - X_LO;
   assign voff   = v - Y_LO;
   assign hoff_n = h_nxt - X_LO;
   assign voff_n = v_nxt - Y_LO;
   assign win    = (hoff < WIN_W_C) && (voff < WIN_H_C);
   assign win_n  = (hoff_n < WIN_W_C) && (voff_n < WIN_H_C);

`ifdef VWT_PIXEL_DOUBLE_EN
   assign adv_line = voff[0];
   assign step_pix = ~hoff_n[0];
`else
   assign adv_line = 1'b1;
   assign step_pix = 1'b1;
`endif

   always_comb begin
      lb_nxt = line_base;
      if (v_wrap)                                     lb_nxt = '0;
      else if (win && hoff == WIN_XLAST && adv_line)  lb_nxt = line_base + LINE_STEP;
   end

   // fb_addr is set up one step early so it matches the (h,v) that fb_rd reports.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h         <= '0;
         v         <= '0;
         line_base <= '0;
         fb_addr   <= '0;
      end else if (ce_pix) begin
         h         <= h_nxt;
         v         <= v_nxt;
         line_base <= lb_nxt;
         if (win_n) begin
            if (hoff_n == '0)  fb_addr <= lb_nxt;
            else if (step_pix) fb_addr <= fb_addr + 1'b1;
         end
      end
   end

   always_comb begin
      flags_now.hs     = (region_of(int'(h), H_ACTIVE, H_FP, H_SYNC) == SYNC) ? HS_POL : ~HS_POL;
      flags_now.vs     = (region_of(int'(v), V_ACTIVE, V_FP, V_SYNC) == SYNC) ? VS_POL : ~VS_POL;
      flags_now.hblank = (region_of(int'(h), H_ACTIVE, H_FP, H_SYNC) != ACTIVE);
      flags_now.vblank = (region_of(int'(v), V_ACTIVE, V_FP, V_SYNC) != ACTIVE);
      flags_now.win    = win;
   end

   sig_delay #(
      .W       ($bits(vflags_t)),
      .DEPTH   (PIPE_LAT),
      .RST_VAL (FLAGS_RST)
   ) u_flag_dly (
      .clk     (clk),
      .reset_n (reset_n),
      .ce      (ce_pix),
      .d       (flags_now),
      .q       (flags_dly)
   );

   assign x           = 11'(h);
   assign y           = 10'(v);
   assign fb_rd       = reset_n && win;
   assign frame_start = reset_n && (h == '0) && (v == '0);
   assign hs          = flags_dly.hs;
   assign vs          = flags_dly.vs;
   assign hblank      = flags_dly.hblank;
   assign vblank      = flags_dly.vblank;
   assign rgb         = (flags_dly.hblank || flags_dly.vblank) ? '0 :
                        flags_dly.win ? pixel_in : border_color;

endmodule

// File: tb/tb_video_window_timing.sv
// Directed bench for video_window_timing on a 14x7 toy raster with a 4x2 screen window.
module tb_video_window_timing;

`ifdef VWT_PIXEL_DOUBLE_EN
   localparam int TW = 2, TH = 1;
`else
   localparam int TW = 4, TH = 2;
`endif
   localparam int HT = 14, VT = 7;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ce_pix = 1'b1;
   logic [11:0] border_color = 12'hF00;
   logic [11:0] pixel_in = 12'h000;
   logic [10:0] x;
   logic [9:0]  y;
   logic [19:0] fb_addr;
   logic        fb_rd, frame_start, hs, vs, hblank, vblank;
   logic [11:0] rgb;

   int checks = 0;
   int passes = 0;
   int s = 0;
   int last_addr = 0;

   video_window_timing #(
      .ADDR_W(20), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1),
      .IMG_X0(2), .IMG_Y0(1), .IMG_W(TW), .IMG_H(TH), .COLOR_W(12), .PIPE_LAT(2)
   ) dut (
      .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .border_color(border_color),
      .pixel_in(pixel_in), .x(x), .y(y), .fb_addr(fb_addr), .fb_rd(fb_rd),
      .frame_start(frame_start), .rgb(rgb), .hs(hs), .vs(vs),
      .hblank(hblank), .vblank(vblank)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, s, obs, exp);
   endtask

   // Screen window is 4x2 at (2,1) in both builds; only the address mapping differs.
   function automatic bit m_win(int st);
      int hh = st % HT, vv = (st / HT) % VT;
      return hh >= 2 && hh < 6 && vv >= 1 && vv < 3;
   endfunction

   function automatic int m_addr(int st);
      int hh = st % HT, vv = (st / HT) % VT;
`ifdef VWT_PIXEL_DOUBLE_EN
      return ((vv - 1) / 2) * TW + (hh - 2) / 2;
`else
      return (vv - 1) * TW + (hh - 2);
`endif
   endfunction

   task automatic chk_reset_state();
      chk("rst_x", int'(x), 0);
      chk("rst_y", int'(y), 0);
      chk("rst_fb_addr", int'(fb_addr), 0);
      chk("rst_fb_rd", int'(fb_rd), 0);
      chk("rst_frame_start", int'(frame_start), 0);
      chk("rst_rgb", int'(rgb), 0);
      chk("rst_hblank", int'(hblank), 1);
      chk("rst_vblank", int'(vblank), 1);
      chk("rst_hs", int'(hs), 0);
      chk("rst_vs", int'(vs), 0);
   endtask

   // Called just after a negedge; asserts reset, checks it took effect at once, releases.
   task automatic do_reset();
      reset_n = 1'b0;
      ce_pix  = 1'b1;
      #1;
      chk_reset_state();
      repeat (2) @(negedge clk);
      reset_n   = 1'b1;
      s         = 0;
      last_addr = 0;
   endtask

   task automatic run_scan(input int ncyc, input bit toggle);
      for (int c = 0; c < ncyc; c++) begin
         int  hh = s % HT, vv = (s / HT) % VT;
         int  d = s - 2;
         bit  ew = m_win(s);
         int  dh, dv;
         bit  dwin, dblank;
         int  erg;
         if (ew) last_addr = m_addr(s);
         if (d >= 0) begin
            dh     = d % HT;
            dv     = (d / HT) % VT;
            dwin   = m_win(d);
            dblank = (dh >= 8) || (dv >= 4);
            pixel_in = dwin ? (12'hA00 | 12'(m_addr(d))) : 12'h5A5;
            erg    = dblank ? 0 : (dwin ? int'(pixel_in) : int'(border_color));
         end else begin
            dh = 0; dv = 0; dwin = 1'b0; dblank = 1'b1;
            pixel_in = 12'h5A5;
            erg = 0;
         end
         #1;
         chk("x", int'(x), hh);
         chk("y", int'(y), vv);
         chk("fb_rd", int'(fb_rd), int'(ew));
         chk("frame_start", int'(frame_start), int'(hh == 0 && vv == 0));
         chk("fb_addr", int'(fb_addr), last_addr);
         chk("rgb", int'(rgb), erg);
         chk("hblank", int'(hblank), d >= 0 ? int'(dh >= 8) : 1);
         chk("vblank", int'(vblank), d >= 0 ? int'(dv >= 4) : 1);
         chk("hs", int'(hs), d >= 0 ? int'(dh >= 10 && dh <= 11) : 0);
         chk("vs", int'(vs), d >= 0 ? int'(dv == 5) : 0);
         ce_pix = toggle ? (c % 2 == 0) : 1'b1;
         @(posedge clk);
         if (ce_pix) s++;
         @(negedge clk);
      end
   endtask

   initial begin
      @(negedge clk);
      do_reset();
      run_scan(2 * HT * VT + 4, 1'b0);
      do_reset();
      run_scan(2 * HT * VT + 24, 1'b1);
      do_reset();
      run_scan(2 * HT + 4, 1'b0);
      chk("pre_reset_x", int'(x), 4);
      chk("pre_reset_y", int'(y), 2);
      do_reset();
      run_scan(HT * VT + 10, 1'b0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
